mmio_port_scheduler: RTL and testbench
======================================

Name: mmio_port_scheduler

Overview:
- Services per-port write notifications coming out of the MMIO controller.
- Each port pulses an inform flag when the CPU writes its odd (data) word. The scheduler latches these as pending requests and picks one port at a time by round-robin.
- It snapshots that port's address/data word pair and hands it to a single shared peripheral service engine over a valid/ready handshake.
- It sits between the MMIO controller's port outputs and the peripheral engine, and reports overrun when the CPU rewrites a port before that port has been serviced.

Parameters:
- PORT_EXPONENT, 2, log2 of port count. PORT_COUNT = 2**PORT_EXPONENT. Each port owns words 2p (address/command) and 2p+1 (data).

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- inform_write  input  PORT_COUNT  one-cycle pulse per port; bit p = CPU wrote word 2p+1.
- port_words  input  32*PORT_COUNT  flattened port_d_out words; bits [32p+15:32p] = word 2p, bits [32p+31:32p+16] = word 2p+1.
- en_mask  input  PORT_COUNT  bit p = 1 makes port p eligible for grant.
- clr_overrun  input  PORT_COUNT  one-cycle pulse; clears overrun bit p.
- svc_valid  output  1  service request to the engine is valid.
- svc_ready  input  1  engine accepts the request.
- svc_port  output  PORT_EXPONENT  index of the granted port.
- svc_addr  output  16  snapshot of word 2p at grant.
- svc_data  output  16  snapshot of word 2p+1 at grant.
- pending  output  PORT_COUNT  current pending request bits.
- overrun  output  PORT_COUNT  sticky overrun flags.
- busy  output  1  high while in state BUSY.

Behaviour:
- Reset (sync, rst=1 at a posedge):
  - state=IDLE, pending=0, overrun=0, rr_ptr=0.
  - svc_valid=0, svc_port=0, svc_addr=0, svc_data=0, busy=0.
  - Reset mid-transaction drops the in-flight request and all pending bits. The engine must treat svc_valid falling as an abort.
- Pending capture:
  - inform_write[p]=1 sets pending[p] at the next edge.
  - All bits are independent, so simultaneous pulses on several ports all latch.
- Eligibility: elig = pending & en_mask. Masked ports keep accumulating pending but are never granted.
- Round-robin:
  - Winner = first eligible index starting at rr_ptr, ascending, wrapping PORT_COUNT-1 -> 0.
  - After each completed handshake, rr_ptr = svc_port+1 (mod PORT_COUNT).
- FSM IDLE:
  - If elig != 0 at a posedge: latch svc_port=winner, svc_addr/svc_data from port_words of the winner in that same cycle, clear pending[winner], then go to BUSY.
  - Else stay in IDLE.
- FSM BUSY:
  - svc_valid=1 and busy=1.
  - svc_port, svc_addr and svc_data are held stable until the handshake.
  - Handshake = svc_valid & svc_ready at a posedge. Next state is IDLE and svc_valid=0.
  - The minimum gap between two grants is one IDLE cycle.
- Latency, uncontended: pulse in cycle N -> pending[p]=1 in N+1 -> svc_valid=1 in N+2.
- Overrun rules:
  - A pulse on p while pending[p]=1 sets overrun[p]. pending[p] stays 1 and the later data wins, because the snapshot is taken at grant.
  - A pulse on p in the same cycle its pending bit is cleared by grant leaves pending[p]=1 and sets no overrun.
  - A pulse on p while p is in BUSY service sets pending[p] with no overrun.
  - clr_overrun[p] and a new overrun on p in the same cycle: set wins.
- en_mask changes take effect on the next IDLE decision and never affect a request already in BUSY.
- svc_ready while in IDLE is ignored.

Test Plan (PORT_EXPONENT=2):
- Reset, then pulse inform_write=4'b0100 with port_words word4=0x1234, word5=0xBEEF, en_mask=4'hF, svc_ready=1 -> svc_valid high 2 cycles after the pulse, svc_port=2, svc_addr=0x1234, svc_data=0xBEEF, pending=0 afterwards, rr_ptr=3.
- Pulse 4'b1011 in one cycle, svc_ready=1 -> grant order 0, 1, 3, each svc_valid for 1 cycle separated by 1 IDLE cycle, with pending shrinking 1011 -> 1010 -> 1000 -> 0000.
- Hold svc_ready=0 for 5 cycles with port 1 granted, and change word3 during the wait -> svc_data stays at the grant-time value. Releasing ready completes the transfer, and rr_ptr=2.
- Pulse port 3 twice before it is granted (en_mask=4'b0111) -> pending=1000 and overrun=1000. Setting en_mask=4'hF grants port 3. clr_overrun=1000 clears overrun.
- Pulse port 0 in the same cycle as both clr_overrun[0] and an existing pending[0]=1 -> overrun[0]=1 (set wins).
- Assert rst for 1 cycle while BUSY with pending=0110 -> next cycle svc_valid=0, pending=0, overrun=0, state IDLE, and a fresh pulse on port 1 is granted first.

Source files
------------

// File: rtl/mmio_port_scheduler_if.sv
// Valid/ready service channel from the port scheduler to the shared peripheral engine.
// The master drives the request; the slave returns ready.
interface mmio_port_scheduler_if #(
    parameter int PORT_EXPONENT = 2
);
    logic                     svc_valid;
    logic                     svc_ready;
    logic [PORT_EXPONENT-1:0] svc_port;
    logic [15:0]              svc_addr;
    logic [15:0]              svc_data;

    modport master (output svc_valid, svc_port, svc_addr, svc_data, input svc_ready);
    modport slave  (input svc_valid, svc_port, svc_addr, svc_data, output svc_ready);
endinterface

// File: rtl/mmio_port_scheduler.sv
// Latches per-port write notifications, grants one port at a time round-robin and
// hands a snapshot of its address/data word pair to the peripheral engine.
module mmio_port_scheduler #(
    parameter  int PORT_EXPONENT = 2,
    localparam int PORT_COUNT    = 2**PORT_EXPONENT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PORT_COUNT-1:0]   inform_write,
    input  logic [32*PORT_COUNT-1:0] port_words,
    input  logic [PORT_COUNT-1:0]   en_mask,
    input  logic [PORT_COUNT-1:0]   clr_overrun,
    mmio_port_scheduler_if.master   svc,
    output logic [PORT_COUNT-1:0]   pending,
    output logic [PORT_COUNT-1:0]   overrun,
    output logic                    busy
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                   state, state_n;
    logic [PORT_EXPONENT-1:0] rr_ptr;
    logic [PORT_EXPONENT-1:0] svc_port_q;
    logic [15:0]              svc_addr_q, svc_data_q;
    logic [PORT_COUNT-1:0]    elig, grant_mask;
    logic [PORT_EXPONENT-1:0] win_idx;
    logic                     win_found;
    logic                     grant, handshake;

    assign elig = pending & en_mask;

    // First eligible port at or after rr_ptr; the PORT_EXPONENT-bit add wraps for free.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (!win_found && elig[rr_ptr + PORT_EXPONENT'(i)]) begin
                win_found = 1'b1;
                win_idx   = rr_ptr + PORT_EXPONENT'(i);
            end
        end
    end

    assign grant      = (state == IDLE) && win_found;
    assign handshake  = (state == BUSY) && svc.svc_ready;
    assign grant_mask = grant ? (PORT_COUNT'(1) << win_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (win_found)     state_n = BUSY;
            BUSY: if (svc.svc_ready) state_n = IDLE;
            default:                 state_n = IDLE;
        endcase
    end

    always_comb begin
        svc.svc_valid = (state == BUSY);
        busy          = (state == BUSY);
    end

    // A pulse landing on the grant cycle re-arms pending but is not an overrun:
    // the snapshot being taken this edge already belongs to the older write.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            overrun    <= '0;
            rr_ptr     <= '0;
            svc_port_q <= '0;
            svc_addr_q <= '0;
            svc_data_q <= '0;
        end else begin
            pending <= (pending & ~grant_mask) | inform_write;
            overrun <= (overrun & ~clr_overrun) | (inform_write & pending & ~grant_mask);
            if (grant) begin
                svc_port_q <= win_idx;
                svc_addr_q <= port_words[32*int'(win_idx) +: 16];
                svc_data_q <= port_words[32*int'(win_idx)+16 +: 16];
            end
            if (handshake) rr_ptr <= svc_port_q + PORT_EXPONENT'(1);
        end
    end

    assign svc.svc_port = svc_port_q;
    assign svc.svc_addr = svc_addr_q;
    assign svc.svc_data = svc_data_q;
endmodule

// File: tb/tb_mmio_port_scheduler.sv
// Bench for mmio_port_scheduler: vector table, directed corner sequences and a
// randomized run against a behavioural model of the scheduling rules.
module tb_mmio_port_scheduler;
    localparam int PE = 2;
    localparam int PC = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [PC-1:0]   inform_write, en_mask, clr_overrun;
    logic [32*PC-1:0] port_words;
    logic [PC-1:0]   pending, overrun;
    logic            busy;

    mmio_port_scheduler_if #(.PORT_EXPONENT(PE)) svc_if();

    mmio_port_scheduler #(.PORT_EXPONENT(PE)) dut (
        .clk(clk), .rst(rst), .inform_write(inform_write), .port_words(port_words),
        .en_mask(en_mask), .clr_overrun(clr_overrun), .svc(svc_if),
        .pending(pending), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] base_addr [PC] = '{16'hA000, 16'hB002, 16'h1234, 16'hD006};
    logic [15:0] base_data [PC] = '{16'hA001, 16'hB003, 16'hBEEF, 16'hD007};

    typedef struct {
        logic       rst;
        logic [3:0] inf;
        logic       v;
        logic [1:0] port;
        logic [3:0] pend;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] port,
                           input logic [15:0] addr, input logic [15:0] data,
                           input logic [3:0] pend, input logic [3:0] ovr);
        chk({tag, ".valid"}, 32'(svc_if.svc_valid), 32'(v));
        chk({tag, ".busy"}, 32'(busy), 32'(v));
        chk({tag, ".pending"}, 32'(pending), 32'(pend));
        chk({tag, ".overrun"}, 32'(overrun), 32'(ovr));
        if (v) begin
            chk({tag, ".port"}, 32'(svc_if.svc_port), 32'(port));
            chk({tag, ".addr"}, 32'(svc_if.svc_addr), 32'(addr));
            chk({tag, ".data"}, 32'(svc_if.svc_data), 32'(data));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_base_words();
        for (int p = 0; p < PC; p++) begin
            port_words[32*p +: 16]    = base_addr[p];
            port_words[32*p+16 +: 16] = base_data[p];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; inform_write = '0; clr_overrun = '0; en_mask = 4'hF;
        svc_if.svc_ready = 1'b1;
        set_base_words();
        step();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] inf, input logic v,
                                input logic [1:0] port, input logic [3:0] pend);
        vec_t t;
        t.rst = r; t.inf = inf; t.v = v; t.port = port; t.pend = pend;
        return t;
    endfunction

    // Behavioural model state
    bit          m_pend [PC];
    bit          m_ovr  [PC];
    bit          m_busy;
    int          m_rr, m_port;
    logic [15:0] m_addr, m_data;

    function automatic logic [3:0] pack(input bit a [PC]);
        logic [3:0] r;
        for (int p = 0; p < PC; p++) r[p] = a[p];
        return r;
    endfunction

    task automatic model_step();
        bit old_pend [PC];
        int granted;
        granted = -1;
        old_pend = m_pend;
        if (m_busy) begin
            if (svc_if.svc_ready) begin
                m_busy = 0;
                m_rr   = (m_port + 1) % PC;
            end
        end else begin
            for (int k = 0; k < PC; k++) begin
                int q;
                q = (m_rr + k) % PC;
                if (granted < 0 && old_pend[q] && en_mask[q]) granted = q;
            end
            if (granted >= 0) begin
                m_busy = 1;
                m_port = granted;
                m_addr = port_words[32*granted +: 16];
                m_data = port_words[32*granted+16 +: 16];
                m_pend[granted] = 0;
            end
        end
        for (int p = 0; p < PC; p++) begin
            if (clr_overrun[p]) m_ovr[p] = 0;
            if (inform_write[p] && old_pend[p] && p != granted) m_ovr[p] = 1;
            if (inform_write[p]) m_pend[p] = 1;
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1; inform_write = '0; clr_overrun = '0; en_mask = 4'hF;
        svc_if.svc_ready = 1'b0; port_words = '0;
        step(); step();
        rst = 1'b0;
        chk("reset.port", 32'(svc_if.svc_port), 32'd0);
        chk("reset.addr", 32'(svc_if.svc_addr), 32'd0);
        chk("reset.data", 32'(svc_if.svc_data), 32'd0);
        chk_out("reset", 1'b0, 2'd0, 16'h0, 16'h0, 4'h0, 4'h0);

        // Table: single grant of port 2, then 1011 from rr=3, then 1011 after reset
        tbl[0]  = mk(0, 4'b0100, 0, 0, 4'b0100);
        tbl[1]  = mk(0, 4'b0000, 1, 2, 4'b0000);
        tbl[2]  = mk(0, 4'b0000, 0, 0, 4'b0000);
        tbl[3]  = mk(0, 4'b1011, 0, 0, 4'b1011);
        tbl[4]  = mk(0, 4'b0000, 1, 3, 4'b0011);
        tbl[5]  = mk(0, 4'b0000, 0, 0, 4'b0011);
        tbl[6]  = mk(0, 4'b0000, 1, 0, 4'b0010);
        tbl[7]  = mk(0, 4'b0000, 0, 0, 4'b0010);
        tbl[8]  = mk(0, 4'b0000, 1, 1, 4'b0000);
        tbl[9]  = mk(0, 4'b0000, 0, 0, 4'b0000);
        tbl[10] = mk(1, 4'b0000, 0, 0, 4'b0000);
        tbl[11] = mk(0, 4'b1011, 0, 0, 4'b1011);
        tbl[12] = mk(0, 4'b0000, 1, 0, 4'b1010);
        tbl[13] = mk(0, 4'b0000, 0, 0, 4'b1010);
        tbl[14] = mk(0, 4'b0000, 1, 1, 4'b1000);
        tbl[15] = mk(0, 4'b0000, 0, 0, 4'b1000);
        tbl[16] = mk(0, 4'b0000, 1, 3, 4'b0000);
        tbl[17] = mk(0, 4'b0000, 0, 0, 4'b0000);
        do_reset();
        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; inform_write = tbl[i].inf;
            step();
            chk_out($sformatf("tbl%0d", i), tbl[i].v, tbl[i].port,
                    base_addr[tbl[i].port], base_data[tbl[i].port], tbl[i].pend, 4'h0);
        end
        rst = 1'b0; inform_write = '0;

        // Stalled engine: snapshot holds while the source word changes
        do_reset();
        svc_if.svc_ready = 1'b0; inform_write = 4'b0010;
        step(); inform_write = '0;
        step();
        chk_out("stall.grant", 1, 1, 16'hB002, 16'hB003, 4'h0, 4'h0);
        port_words[63:48] = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("stall.hold%0d", i), 1, 1, 16'hB002, 16'hB003, 4'h0, 4'h0);
        end
        svc_if.svc_ready = 1'b1;
        step();
        chk_out("stall.release", 0, 0, 16'h0, 16'h0, 4'h0, 4'h0);
        set_base_words(); inform_write = 4'b1011;
        step(); inform_write = '0;
        step();
        chk_out("stall.rr2", 1, 3, 16'hD006, 16'hD007, 4'b0011, 4'h0);
        step();

        // Overrun on a masked port, then grant and clear
        do_reset();
        en_mask = 4'b0111; inform_write = 4'b1000;
        step();
        chk_out("ovr.first", 0, 0, 16'h0, 16'h0, 4'b1000, 4'h0);
        step(); inform_write = '0;
        chk_out("ovr.second", 0, 0, 16'h0, 16'h0, 4'b1000, 4'b1000);
        step();
        chk_out("ovr.masked", 0, 0, 16'h0, 16'h0, 4'b1000, 4'b1000);
        en_mask = 4'hF;
        step();
        chk_out("ovr.grant", 1, 3, 16'hD006, 16'hD007, 4'h0, 4'b1000);
        step();
        clr_overrun = 4'b1000;
        step(); clr_overrun = '0;
        chk_out("ovr.clear", 0, 0, 16'h0, 16'h0, 4'h0, 4'h0);

        // Set beats clear on the same cycle
        do_reset();
        en_mask = 4'h0; inform_write = 4'b0001;
        step();
        clr_overrun = 4'b0001;
        step(); inform_write = '0;
        chk_out("setwins", 0, 0, 16'h0, 16'h0, 4'b0001, 4'b0001);
        step(); clr_overrun = '0;
        chk_out("setwins.clr", 0, 0, 16'h0, 16'h0, 4'b0001, 4'h0);

        // Pulse on the grant cycle, then pulses while busy, then reset mid-transaction
        do_reset();
        svc_if.svc_ready = 1'b0; inform_write = 4'b0001;
        step();
        step();
        chk_out("grantpulse", 1, 0, 16'hA000, 16'hA001, 4'b0001, 4'h0);
        inform_write = 4'b0110;
        step();
        chk_out("busypulse", 1, 0, 16'hA000, 16'hA001, 4'b0111, 4'h0);
        step();
        chk_out("busyovr", 1, 0, 16'hA000, 16'hA001, 4'b0111, 4'b0110);
        inform_write = '0; rst = 1'b1;
        step(); rst = 1'b0;
        chk_out("midrst", 0, 0, 16'h0, 16'h0, 4'h0, 4'h0);
        chk("midrst.port", 32'(svc_if.svc_port), 32'd0);
        svc_if.svc_ready = 1'b1; inform_write = 4'b0010;
        step(); inform_write = '0;
        step();
        chk_out("midrst.fresh", 1, 1, 16'hB002, 16'hB003, 4'h0, 4'h0);

        // Randomized run against the behavioural model
        do_reset();
        for (int p = 0; p < PC; p++) begin m_pend[p] = 0; m_ovr[p] = 0; end
        m_busy = 0; m_rr = 0; m_port = 0; m_addr = '0; m_data = '0;
        for (int c = 0; c < 400; c++) begin
            inform_write     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            clr_overrun      = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            en_mask          = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            svc_if.svc_ready = 1'($urandom);
            if ($urandom_range(0, 3) == 0)
                for (int p = 0; p < PC; p++) port_words[32*p +: 32] = $urandom;
            model_step();
            step();
            chk_out($sformatf("rand%0d", c), m_busy, 2'(m_port), m_addr, m_data,
                    pack(m_pend), pack(m_ovr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
